// File: rtl/fir_tap_sequencer_if.sv
// Bus bundle between the FIR tap sequencer, its sample source, the
// coefficient ROM and the SB_MAC16 accumulator.
//
// Handshake: a sample transfers on a rising CLK edge where sample_valid and
// sample_ready are both high. sample_valid may rise at any time; once high,
// the source holds sample_in stable until that transfer edge. sample_ready
// does not depend on sample_valid. y_valid is a one-cycle pulse and has no
// back-pressure.
interface fir_tap_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic [15:0]       sample_in;
    logic              sample_valid;
    logic              sample_ready;
    logic [ADDR_W-1:0] coef_addr;
    logic [15:0]       coef_data;
    logic [15:0]       mac_a;
    logic [15:0]       mac_b;
    logic              mac_ce;
    logic              mac_rst;
    logic [31:0]       mac_o;
    logic [15:0]       y_out;
    logic              y_valid;

    // Environment side: sample source, coefficient ROM, MAC, result sink
    modport master (
        output sample_in, sample_valid, coef_data, mac_o,
        input  sample_ready, coef_addr, mac_a, mac_b, mac_ce, mac_rst, y_out, y_valid
    );

    // Sequencer side
    modport slave (
        input  sample_in, sample_valid, coef_data, mac_o,
        output sample_ready, coef_addr, mac_a, mac_b, mac_ce, mac_rst, y_out, y_valid
    );
endinterface

// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: stores samples in a circular delay line, streams
// sample/coefficient pairs into an external SB_MAC16, then floors and
// saturates the accumulated sum to a 16-bit output.
module fir_tap_sequencer #(
    parameter int NUM_TAPS  = 16,
    parameter int ADDR_W    = 4,
    parameter int OUT_SHIFT = 15
) (
    input  logic                 CLK,
    input  logic                 RST,
    fir_tap_sequencer_if.slave   bus,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   newest_ptr;
    logic [ADDR_W-1:0]   tap_cnt;
    logic [ADDR_W-1:0]   rd_addr;
    logic [ADDR_W:0]     fill_cnt;
    logic [15:0]         ram [NUM_TAPS];
    logic [15:0]         ram_q;
    logic                accept;
    logic                last_tap;
    logic                tap_live;
    logic signed [31:0]  acc_shift;
    logic [15:0]         y_sat;

    assign accept    = bus.sample_valid && bus.sample_ready;
    assign last_tap  = (tap_cnt == ADDR_W'(NUM_TAPS - 1));
    // Taps older than the number of samples seen so far read stale RAM
    assign tap_live  = ({1'b0, tap_cnt} <= fill_cnt);
    // Tap index issued this cycle equals the coefficient address
    assign rd_addr   = newest_ptr - bus.coef_addr;
    assign state_dbg = state;

    // Floor shift of the accumulator, then clamp to the 16-bit signed range
    assign acc_shift = $signed(bus.mac_o) >>> OUT_SHIFT;
    assign y_sat     = (acc_shift > 32'sd32767)  ? 16'h7FFF :
                       (acc_shift < -32'sd32768) ? 16'h8000 :
                       acc_shift[15:0];

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CLEAR;
            CLEAR:   state_nxt = RUN;
            RUN:     if (last_tap) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; read address for tap j+1 issued in RUN cycle j
    always_comb begin
        bus.sample_ready = (state == IDLE) && !RST;
        bus.mac_rst      = (state == CLEAR);
        bus.mac_ce       = (state == RUN);
        bus.coef_addr    = '0;
        bus.mac_a        = '0;
        bus.mac_b        = '0;
        if (state == RUN) begin
            bus.coef_addr = tap_cnt + ADDR_W'(1);
            bus.mac_a     = tap_live ? ram_q : 16'h0000;
            bus.mac_b     = bus.coef_data;
        end
    end

    // Delay-line RAM: write on accept, synchronous read (BRAM style, no reset)
    always_ff @(posedge CLK) begin
        if (accept) ram[wr_ptr] <= bus.sample_in;
        ram_q <= ram[rd_addr];
    end

    // Pointers and fill count; pointer advances only once the run completes
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr     <= '0;
            newest_ptr <= '0;
            fill_cnt   <= '0;
        end else begin
            if (accept) newest_ptr <= wr_ptr;
            if (state == DONE) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
                if (fill_cnt != (ADDR_W+1)'(NUM_TAPS))
                    fill_cnt <= fill_cnt + (ADDR_W+1)'(1);
            end
        end
    end

    // Tap counter: cleared in CLEAR, walks 0..NUM_TAPS-1 through RUN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                 tap_cnt <= '0;
        else if (state == CLEAR) tap_cnt <= '0;
        else if (state == RUN)   tap_cnt <= tap_cnt + ADDR_W'(1);
    end

    // Result capture in DONE; y_valid pulses in the following IDLE cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.y_out   <= '0;
            bus.y_valid <= 1'b0;
        end else begin
            bus.y_valid <= (state == DONE);
            if (state == DONE) bus.y_out <= y_sat;
        end
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer with NUM_TAPS=4: impulse response,
// handshake timing, saturation, pointer wrap and reset during a run.
module tb_fir_tap_sequencer;

    localparam int NT = 4;
    localparam int AW = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  state_dbg;
    int          vectors = 0;
    int          miscompares = 0;

    logic [15:0]        coef_rom [NT];
    logic signed [31:0] acc = 32'sd0;

    fir_tap_sequencer_if #(.ADDR_W(AW)) bus ();

    fir_tap_sequencer #(.NUM_TAPS(NT), .ADDR_W(AW), .OUT_SHIFT(15)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock
    always #5 CLK = ~CLK;

    // Coefficient ROM with one-cycle read latency
    always @(posedge CLK) bus.coef_data <= coef_rom[bus.coef_addr];

    // SB_MAC16 accumulator model
    always @(posedge CLK) begin
        if (bus.mac_rst)
            acc <= 32'sd0;
        else if (bus.mac_ce)
            acc <= acc + $signed(bus.mac_a) * $signed(bus.mac_b);
    end
    assign bus.mac_o = acc;

    task automatic check_val(input string tag, input logic signed [31:0] act,
                             input logic signed [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic set_coefs(input logic [15:0] c0, input logic [15:0] c1,
                             input logic [15:0] c2, input logic [15:0] c3);
        coef_rom[0] = c0;
        coef_rom[1] = c1;
        coef_rom[2] = c2;
        coef_rom[3] = c3;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Drive one sample through the handshake and wait (bounded) for its result
    task automatic send_sample(input logic [15:0] x, output logic [15:0] y,
                               output logic ok);
        int n;
        ok = 1'b0;
        y  = '0;
        n  = 0;
        @(negedge CLK);
        while (!bus.sample_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        bus.sample_in    = x;
        bus.sample_valid = 1'b1;
        @(posedge CLK);
        #1 bus.sample_valid = 1'b0;
        n = 0;
        while (n < 50 && !ok) begin
            @(negedge CLK);
            if (bus.y_valid) begin
                ok = 1'b1;
                y  = bus.y_out;
            end
            n++;
        end
    endtask

    task automatic run_vec(input string tag, input logic [15:0] x, input int exp);
        logic [15:0] y;
        logic        ok;
        send_sample(x, y, ok);
        check_val({tag, "_done"}, {31'd0, ok}, 32'sd1);
        check_val(tag, $signed(y), exp);
    endtask

    initial begin
        int ramp_exp [10];
        int hs_ready [8];
        int hs_rst   [8];
        int hs_ce    [8];
        int hs_yv    [8];
        int yv_seen;
        logic [15:0] y;
        logic        ok;

        ramp_exp = '{0, 1, 2, 4, 6, 8, 10, 12, 14, 16};
        hs_ready = '{1, 0, 0, 0, 0, 0, 0, 1};
        hs_rst   = '{0, 1, 0, 0, 0, 0, 0, 0};
        hs_ce    = '{0, 0, 1, 1, 1, 1, 0, 0};
        hs_yv    = '{0, 0, 0, 0, 0, 0, 0, 1};

        bus.sample_in    = '0;
        bus.sample_valid = 1'b0;
        set_coefs(16'h4000, 16'h2000, 16'h1000, 16'h0800);

        // Reset state while RST is held
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_val("rst_ready",   bus.sample_ready, 0);
        check_val("rst_mac_ce",  bus.mac_ce, 0);
        check_val("rst_mac_rst", bus.mac_rst, 0);
        check_val("rst_coef",    bus.coef_addr, 0);
        check_val("rst_y_out",   bus.y_out, 0);
        check_val("rst_y_valid", bus.y_valid, 0);
        check_val("rst_state",   state_dbg, 0);
        check_val("rst_mac_a",   bus.mac_a, 0);
        RST = 1'b0;
        @(negedge CLK);
        check_val("idle_ready", bus.sample_ready, 1);

        // Impulse response
        run_vec("imp0", 16'h7FFF, 16383);
        run_vec("imp1", 16'h0000, 8191);
        run_vec("imp2", 16'h0000, 4095);
        run_vec("imp3", 16'h0000, 2047);
        run_vec("imp4", 16'h0000, 0);

        // Handshake/latency with sample_valid held high from t0
        do_reset();
        @(negedge CLK);
        bus.sample_in    = 16'h7FFF;
        bus.sample_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge CLK);
            check_val($sformatf("hs_ready_t%0d", k), bus.sample_ready, hs_ready[k]);
            check_val($sformatf("hs_mrst_t%0d", k),  bus.mac_rst, hs_rst[k]);
            check_val($sformatf("hs_ce_t%0d", k),    bus.mac_ce, hs_ce[k]);
            check_val($sformatf("hs_yv_t%0d", k),    bus.y_valid, hs_yv[k]);
            check_val($sformatf("hs_excl_t%0d", k),  bus.mac_rst & bus.mac_ce, 0);
        end
        check_val("hs_y0", $signed(bus.y_out), 16383);
        @(posedge CLK);
        #1 bus.sample_valid = 1'b0;
        yv_seen = 0;
        for (int k = 0; k < 20 && yv_seen == 0; k++) begin
            @(negedge CLK);
            if (bus.y_valid) begin
                yv_seen = 1;
                check_val("hs_y1", $signed(bus.y_out), 24575);
            end
        end
        check_val("hs_y1_done", yv_seen, 1);

        // Positive saturation
        do_reset();
        set_coefs(16'h4000, 16'h4000, 16'h4000, 16'h4000);
        run_vec("psat0", 16'h7FFF, 16383);
        run_vec("psat1", 16'h7FFF, 32767);
        run_vec("psat2", 16'h7FFF, 32767);
        run_vec("psat3", 16'h7FFF, 32767);

        // Negative saturation
        do_reset();
        run_vec("nsat0", 16'h8000, -16384);
        run_vec("nsat1", 16'h8000, -32768);
        run_vec("nsat2", 16'h8000, -32768);
        run_vec("nsat3", 16'h8000, -32768);

        // Pointer wrap with a ramp; stale -32768 entries must stay masked
        do_reset();
        set_coefs(16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF);
        for (int n = 1; n <= 10; n++)
            run_vec($sformatf("wrap%0d", n), 16'(n), ramp_exp[n-1]);

        // Reset during RUN cycle 2
        set_coefs(16'h4000, 16'h2000, 16'h1000, 16'h0800);
        @(negedge CLK);
        bus.sample_in    = 16'h7FFF;
        bus.sample_valid = 1'b1;
        @(posedge CLK);
        #1 bus.sample_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        check_val("mid_state_run", state_dbg, 2);
        check_val("mid_ce_run",    bus.mac_ce, 1);
        RST = 1'b1;
        #1;
        check_val("mid_state", state_dbg, 0);
        check_val("mid_ce",    bus.mac_ce, 0);
        check_val("mid_mrst",  bus.mac_rst, 0);
        check_val("mid_ready", bus.sample_ready, 0);
        check_val("mid_coef",  bus.coef_addr, 0);
        check_val("mid_mac_a", bus.mac_a, 0);
        check_val("mid_y_out", bus.y_out, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        yv_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (bus.y_valid) yv_seen++;
        end
        check_val("mid_no_yvalid", yv_seen, 0);
        run_vec("post0", 16'h7FFF, 16383);
        run_vec("post1", 16'h0000, 8191);
        run_vec("post2", 16'h0000, 4095);
        run_vec("post3", 16'h0000, 2047);
        run_vec("post4", 16'h0000, 0);

        // Result stays held after the pulse
        send_sample(16'h0000, y, ok);
        @(negedge CLK);
        check_val("hold_yv", bus.y_valid, 0);
        check_val("hold_y",  $signed(bus.y_out), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
